// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port arbiter in front of the 32-byte memory:
// FSM state encoding, port identifiers and default bus widths.
package memory_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_ACCESS    = 2'd1;
    localparam state_t ST_READ_WAIT = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick. When both requesters are valid the
// port that did not win last time is chosen; a lone requester always wins.
module rr_arbiter_2
    import memory_arbiter_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    input  logic enable_i,
    output logic grant_id_o,
    output logic grant_valid_o
);

    // Pick the winner; grant_valid_o is suppressed while the owner is busy.
    always_comb begin
        grant_valid_o = enable_i && (valid0_i || valid1_i);
        if (valid0_i && valid1_i) begin
            grant_id_o = ~last_grant_i;
        end else if (valid1_i) begin
            grant_id_o = PORT1;
        end else begin
            grant_id_o = PORT0;
        end
    end

endmodule

// File: rtl/memory_32byte_arbiter.sv
// Two-port round-robin access controller for the shared 32-byte memory.
// Accepts one single-beat read or write at a time, drives the memory control
// lines from latched command registers and routes read data back to the
// issuing port. Optional per-port accept counters: define ARB_GRANT_COUNT_EN.
module memory_32byte_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int READ_LATENCY = 1
`ifdef ARB_GRANT_COUNT_EN
    , parameter int COUNT_WIDTH = 8
`endif
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
`ifdef ARB_GRANT_COUNT_EN
    , output logic [COUNT_WIDTH-1:0] grant_count0
    , output logic [COUNT_WIDTH-1:0] grant_count1
`endif
);

    // READ_WAIT counts down from READ_LATENCY-2 to zero; keep at least one bit.
    localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  cmd_port_q, cmd_port_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic grant_id;
    logic accept;
    logic read_done;

    rr_arbiter_2 u_rr_arbiter_2 (
        .valid0_i      (req0_valid),
        .valid1_i      (req1_valid),
        .last_grant_i  (last_grant_q),
        .enable_i      (state_q == ST_IDLE),
        .grant_id_o    (grant_id),
        .grant_valid_o (accept)
    );

    assign req0_ready  = accept && (grant_id == PORT0);
    assign req1_ready  = accept && (grant_id == PORT1);

    assign mem_address = cmd_addr_q;
    assign mem_data_in = cmd_wdata_q;
    assign mem_write   = cmd_write_q && (state_q == ST_ACCESS);
    assign mem_read    = !cmd_write_q &&
                         ((state_q == ST_ACCESS) || (state_q == ST_READ_WAIT));
    assign busy        = (state_q != ST_IDLE);

    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    // Flag the final cycle of a read, when memory output is captured.
    always_comb begin
        read_done = 1'b0;
        if (!cmd_write_q) begin
            if ((state_q == ST_ACCESS) && (READ_LATENCY == 1)) begin
                read_done = 1'b1;
            end
            if ((state_q == ST_READ_WAIT) && (wait_cnt_q == '0)) begin
                read_done = 1'b1;
            end
        end
    end

    // FSM next state plus command latching on accept.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_port_d   = cmd_port_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_ACCESS;
                    last_grant_d = grant_id;
                    cmd_port_d   = grant_id;
                    cmd_write_d  = (grant_id == PORT1) ? req1_write   : req0_write;
                    cmd_addr_d   = (grant_id == PORT1) ? req1_address : req0_address;
                    cmd_wdata_d  = (grant_id == PORT1) ? req1_wdata   : req0_wdata;
                end
            end
            ST_ACCESS: begin
                if (cmd_write_q || (READ_LATENCY == 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_READ_WAIT;
                    wait_cnt_d = WAIT_W'(READ_LATENCY - 2);
                end
            end
            ST_READ_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Route captured read data and a one-cycle valid pulse to the issuer.
    always_comb begin
        rvalid0_d = read_done && (cmd_port_q == PORT0);
        rvalid1_d = read_done && (cmd_port_q == PORT1);
        rdata0_d  = rvalid0_d ? mem_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_data_out : rdata1_q;
    end

    // State, command and response registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT1;
            cmd_port_q   <= PORT0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            wait_cnt_q   <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_port_q   <= cmd_port_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

`ifdef ARB_GRANT_COUNT_EN
    logic [COUNT_WIDTH-1:0] count0_q, count0_d;
    logic [COUNT_WIDTH-1:0] count1_q, count1_d;

    // Saturating per-port accept counters.
    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (req0_ready && (count0_q != '1)) begin
            count0_d = count0_q + 1'b1;
        end
        if (req1_ready && (count1_q != '1)) begin
            count1_d = count1_q + 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign grant_count0 = count0_q;
    assign grant_count1 = count1_q;
`endif

endmodule

// File: tb/tb_memory_32byte_arbiter.sv
// Directed self-checking bench for memory_32byte_arbiter. Instance dutA uses
// READ_LATENCY=1, instance dutB uses READ_LATENCY=3; each has its own 32-byte
// memory model with combinational read and clocked write.
module tb_memory_32byte_arbiter;

    logic clock;
    logic reset;

    int checkCount;
    int errorCount;

    // Instance A signals
    logic       a0Valid, a0Write, a0Ready, a0Rvalid;
    logic [4:0] a0Addr;
    logic [7:0] a0Wdata, a0Rdata;
    logic       a1Valid, a1Write, a1Ready, a1Rvalid;
    logic [4:0] a1Addr;
    logic [7:0] a1Wdata, a1Rdata;
    logic [4:0] aMemAddr;
    logic [7:0] aMemDin, aMemDout;
    logic       aMemRead, aMemWrite, aBusy;
    logic [7:0] memA [32];
`ifdef ARB_GRANT_COUNT_EN
    logic [1:0] aCount0, aCount1;
`endif

    // Instance B signals
    logic       b0Valid, b0Write, b0Ready, b0Rvalid;
    logic [4:0] b0Addr;
    logic [7:0] b0Wdata, b0Rdata;
    logic       b1Valid, b1Write, b1Ready, b1Rvalid;
    logic [4:0] b1Addr;
    logic [7:0] b1Wdata, b1Rdata;
    logic [4:0] bMemAddr;
    logic [7:0] bMemDin, bMemDout;
    logic       bMemRead, bMemWrite, bBusy;
    logic [7:0] memB [32];

    memory_32byte_arbiter #(
        .ADDR_WIDTH   (5),
        .DATA_WIDTH   (8),
        .READ_LATENCY (1)
`ifdef ARB_GRANT_COUNT_EN
        , .COUNT_WIDTH (2)
`endif
    ) dutA (
        .clock        (clock),
        .reset        (reset),
        .req0_valid   (a0Valid),
        .req0_write   (a0Write),
        .req0_address (a0Addr),
        .req0_wdata   (a0Wdata),
        .req0_ready   (a0Ready),
        .req0_rvalid  (a0Rvalid),
        .req0_rdata   (a0Rdata),
        .req1_valid   (a1Valid),
        .req1_write   (a1Write),
        .req1_address (a1Addr),
        .req1_wdata   (a1Wdata),
        .req1_ready   (a1Ready),
        .req1_rvalid  (a1Rvalid),
        .req1_rdata   (a1Rdata),
        .mem_address  (aMemAddr),
        .mem_data_in  (aMemDin),
        .mem_read     (aMemRead),
        .mem_write    (aMemWrite),
        .mem_data_out (aMemDout),
        .busy         (aBusy)
`ifdef ARB_GRANT_COUNT_EN
        , .grant_count0 (aCount0)
        , .grant_count1 (aCount1)
`endif
    );

    memory_32byte_arbiter #(
        .ADDR_WIDTH   (5),
        .DATA_WIDTH   (8),
        .READ_LATENCY (3)
`ifdef ARB_GRANT_COUNT_EN
        , .COUNT_WIDTH (2)
`endif
    ) dutB (
        .clock        (clock),
        .reset        (reset),
        .req0_valid   (b0Valid),
        .req0_write   (b0Write),
        .req0_address (b0Addr),
        .req0_wdata   (b0Wdata),
        .req0_ready   (b0Ready),
        .req0_rvalid  (b0Rvalid),
        .req0_rdata   (b0Rdata),
        .req1_valid   (b1Valid),
        .req1_write   (b1Write),
        .req1_address (b1Addr),
        .req1_wdata   (b1Wdata),
        .req1_ready   (b1Ready),
        .req1_rvalid  (b1Rvalid),
        .req1_rdata   (b1Rdata),
        .mem_address  (bMemAddr),
        .mem_data_in  (bMemDin),
        .mem_read     (bMemRead),
        .mem_write    (bMemWrite),
        .mem_data_out (bMemDout),
        .busy         (bBusy)
`ifdef ARB_GRANT_COUNT_EN
        , .grant_count0 ()
        , .grant_count1 ()
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory models: cleared on reset, location 31 of memory B preloaded.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                memA[i] <= 8'h00;
                memB[i] <= (i == 31) ? 8'h5A : 8'h00;
            end
        end else begin
            if (aMemWrite) memA[aMemAddr] <= aMemDin;
            if (bMemWrite) memB[bMemAddr] <= bMemDin;
        end
    end

    assign aMemDout = memA[aMemAddr];
    assign bMemDout = memB[bMemAddr];

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one command on a port of instance A.
    task automatic applyStimulus(input int port, input logic valid, input logic write,
                                 input logic [4:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            a0Valid = valid; a0Write = write; a0Addr = addr; a0Wdata = wdata;
        end else begin
            a1Valid = valid; a1Write = write; a1Addr = addr; a1Wdata = wdata;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Directed sequence.
    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);
        b0Valid = 1'b0; b0Write = 1'b0; b0Addr = 5'd0; b0Wdata = 8'd0;
        b1Valid = 1'b0; b1Write = 1'b0; b1Addr = 5'd0; b1Wdata = 8'd0;

        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_mem_address", aMemAddr, 0);
        checkOutput("rst_mem_data_in", aMemDin, 0);
        checkOutput("rst_mem_read", aMemRead, 0);
        checkOutput("rst_mem_write", aMemWrite, 0);
        checkOutput("rst_busy", aBusy, 0);
        checkOutput("rst_rvalid0", a0Rvalid, 0);
        checkOutput("rst_rvalid1", a1Rvalid, 0);
        checkOutput("rst_rdata0", a0Rdata, 0);
        checkOutput("rst_rdata1", a1Rdata, 0);
        checkOutput("rst_b_ready1", b1Ready, 0);
        checkOutput("rst_b_rdata1", b1Rdata, 0);
        checkOutput("rst_b_mem_data_in", bMemDin, 0);
        reset = 1'b0;

        $display("[TB] port 0 write 25 to address 30");
        applyStimulus(0, 1'b1, 1'b1, 5'd30, 8'd25);
        #1;
        checkOutput("wr_ready0", a0Ready, 1);
        checkOutput("wr_ready1", a1Ready, 0);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 5'd7, 8'd0);
        #1;
        checkOutput("busy_ready0", a0Ready, 0);
        checkOutput("wr_mem_write", aMemWrite, 1);
        checkOutput("wr_mem_read", aMemRead, 0);
        checkOutput("wr_mem_address", aMemAddr, 30);
        checkOutput("wr_mem_data_in", aMemDin, 25);
        checkOutput("wr_busy", aBusy, 1);
        applyStimulus(0, 1'b0, 1'b0, 5'd7, 8'd0);
        tick();
        checkOutput("wr_done_mem_write", aMemWrite, 0);
        checkOutput("wr_done_busy", aBusy, 0);
        applyStimulus(0, 1'b1, 1'b0, 5'd7, 8'd0);
        #1;
        checkOutput("wr_ready_again", a0Ready, 1);
        applyStimulus(0, 1'b0, 1'b0, 5'd7, 8'd0);

        $display("[TB] port 1 read address 30");
        applyStimulus(1, 1'b1, 1'b0, 5'd30, 8'd0);
        #1;
        checkOutput("rd_ready1", a1Ready, 1);
        checkOutput("rd_ready0", a0Ready, 0);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);
        checkOutput("rd_mem_read", aMemRead, 1);
        checkOutput("rd_mem_write", aMemWrite, 0);
        checkOutput("rd_mem_address", aMemAddr, 30);
        checkOutput("rd_busy", aBusy, 1);
        checkOutput("rd_early_rvalid1", a1Rvalid, 0);
        tick();
        checkOutput("rd_rvalid1", a1Rvalid, 1);
        checkOutput("rd_rdata1", a1Rdata, 25);
        checkOutput("rd_rvalid0", a0Rvalid, 0);
        checkOutput("rd_idle_busy", aBusy, 0);
        tick();
        checkOutput("rd_rvalid1_pulse", a1Rvalid, 0);
        checkOutput("rd_rdata1_hold", a1Rdata, 25);

        $display("[TB] both ports writing continuously");
        applyStimulus(0, 1'b1, 1'b1, 5'd20, 8'd15);
        applyStimulus(1, 1'b1, 1'b1, 5'd10, 8'd18);
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("rr_ready0", a0Ready, ((i % 4) == 0) ? 1 : 0);
            checkOutput("rr_ready1", a1Ready, ((i % 4) == 2) ? 1 : 0);
            checkOutput("rr_both_ready", a0Ready & a1Ready, 0);
            if ((i % 2) == 1) begin
                checkOutput("rr_mem_write", aMemWrite, 1);
                checkOutput("rr_mem_address", aMemAddr, ((i % 4) == 1) ? 20 : 10);
                checkOutput("rr_mem_data_in", aMemDin, ((i % 4) == 1) ? 15 : 18);
            end
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);

        $display("[TB] read back both written locations");
        applyStimulus(0, 1'b1, 1'b0, 5'd10, 8'd0);
        #1;
        checkOutput("rb_ready0", a0Ready, 1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        checkOutput("rb_rvalid0", a0Rvalid, 1);
        checkOutput("rb_rdata0", a0Rdata, 18);
        checkOutput("rb_rvalid1", a1Rvalid, 0);
        applyStimulus(1, 1'b1, 1'b0, 5'd20, 8'd0);
        #1;
        checkOutput("rb_accept_with_rvalid", a1Ready, 1);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        checkOutput("rb_rvalid1b", a1Rvalid, 1);
        checkOutput("rb_rdata1b", a1Rdata, 15);
        checkOutput("rb_rdata0_hold", a0Rdata, 18);

        $display("[TB] reset in the middle of a read");
        applyStimulus(0, 1'b1, 1'b0, 5'd5, 8'd0);
        #1;
        checkOutput("mr_ready0", a0Ready, 1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
        reset = 1'b1;
        checkOutput("mr_mem_read_before", aMemRead, 1);
        tick();
        reset = 1'b0;
        checkOutput("mr_mem_read", aMemRead, 0);
        checkOutput("mr_busy", aBusy, 0);
        checkOutput("mr_rvalid0", a0Rvalid, 0);
        checkOutput("mr_rdata0", a0Rdata, 0);
        checkOutput("mr_mem_address", aMemAddr, 0);
        applyStimulus(0, 1'b1, 1'b1, 5'd3, 8'h33);
        applyStimulus(1, 1'b1, 1'b1, 5'd4, 8'h44);
        #1;
        checkOutput("mr_contend_ready0", a0Ready, 1);
        checkOutput("mr_contend_ready1", a1Ready, 0);
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);

`ifdef ARB_GRANT_COUNT_EN
        $display("[TB] grant counter saturation");
        checkOutput("cnt_reset0", aCount0, 0);
        checkOutput("cnt_reset1", aCount1, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1'b1, 1'b1, 5'(k), 8'(k));
            tick();
            applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);
            tick();
        end
        checkOutput("cnt_sat1", aCount1, 3);
        checkOutput("cnt_port0", aCount0, 0);
`endif

        $display("[TB] port 0 read address 31 with three-cycle latency");
        b0Valid = 1'b1; b0Write = 1'b0; b0Addr = 5'd31;
        #1;
        checkOutput("l3_ready0", b0Ready, 1);
        tick();
        b0Valid = 1'b0;
        checkOutput("l3_mem_read_1", bMemRead, 1);
        checkOutput("l3_mem_address", bMemAddr, 31);
        checkOutput("l3_busy_1", bBusy, 1);
        checkOutput("l3_mem_write", bMemWrite, 0);
        tick();
        checkOutput("l3_mem_read_2", bMemRead, 1);
        tick();
        checkOutput("l3_mem_read_3", bMemRead, 1);
        checkOutput("l3_busy_3", bBusy, 1);
        checkOutput("l3_early_rvalid", b0Rvalid, 0);
        tick();
        checkOutput("l3_mem_read_end", bMemRead, 0);
        checkOutput("l3_busy_end", bBusy, 0);
        checkOutput("l3_rvalid0", b0Rvalid, 1);
        checkOutput("l3_rdata0", b0Rdata, 8'h5A);
        checkOutput("l3_addr_hold", bMemAddr, 31);
        tick();
        checkOutput("l3_rvalid0_pulse", b0Rvalid, 0);
        checkOutput("l3_rvalid1", b1Rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/memory_32byte_arbiter.md
# memory_32byte_arbiter

Two-port round-robin access controller in front of the shared 32-byte memory (`Memory_32byte`). Two requesters issue single-beat read or write commands over a valid/ready handshake. The block grants one at a time and sequences the memory's `read`/`write`/`address`/`I` inputs. It also returns read data to the requester that issued the command.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, memory address width (32 locations)
- `DATA_WIDTH`, 8, data word width
- `READ_LATENCY`, 1, cycles `mem_read` is held before `mem_data_out` is sampled (≥1)
- `COUNT_WIDTH`, 8, grant counter width (only with `ARB_GRANT_COUNT_EN`)

Ports:
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req0_valid`  in  1  port 0 command valid
- `req0_write`  in  1  1 = write, 0 = read
- `req0_address`  in  ADDR_WIDTH  target address
- `req0_wdata`  in  DATA_WIDTH  write data
- `req0_ready`  out  1  command accepted this cycle when high with `req0_valid`
- `req0_rvalid`  out  1  one-cycle read response pulse
- `req0_rdata`  out  DATA_WIDTH  read data, held until next port-0 read response
- `req1_*`  identical set for port 1
- `mem_address`  out  ADDR_WIDTH  to memory `address`
- `mem_data_in`  out  DATA_WIDTH  to memory `I`
- `mem_read`  out  1  to memory `read`
- `mem_write`  out  1  to memory `write`
- `mem_data_out`  in  DATA_WIDTH  from memory `O`
- `busy`  out  1  high whenever state ≠ IDLE
- `grant_count0`, `grant_count1`  out  COUNT_WIDTH  accepted commands per port (macro only)

## Operation
- FSM states:
  - IDLE:
    - → ACCESS on any accept.
  - ACCESS:
    - Write → IDLE after 1 cycle.
    - Read with `READ_LATENCY`=1 → IDLE.
    - Read with `READ_LATENCY`>1 → READ_WAIT.
  - READ_WAIT:
    - Counts `READ_LATENCY`−1 cycles → IDLE.
- `reqN_ready` is combinational: high only in IDLE, for the granted port, when that port's valid is high.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: grant the port not granted last.
  - `last_grant` updates on every accept.
- On accept, latch port id, write flag, address and wdata into command registers. `mem_address`/`mem_data_in` are driven from these registers and held stable for the whole transaction.
- `mem_read` and `mem_write` are never both high. Both are 0 in IDLE.
- Read data: sample `mem_data_out` at the last rising edge of the read. Load it into the issuing port's `rdata` and pulse that port's `rvalid`.
- Addresses 0 and 31 pass unchanged; no wrap or offset arithmetic.
- Reset values:
  - state IDLE, `last_grant`=1 (port 0 wins first contention)
  - `mem_address`=0, `mem_data_in`=0, `mem_read`=0, `mem_write`=0
  - `busy`=0, `rvalid`s=0, `rdata`s=0, counters=0
- Boundary cases:
  - Valid while busy: ready=0; requester must hold the command stable.
  - Valid dropped before accept: no effect.
  - Reset mid-transaction: next cycle all outputs at reset values, no `rvalid` for the aborted read, write may or may not have reached memory.
  - Simultaneous `rvalid` pulse and new accept in IDLE is legal.

## Timing
- Accept in cycle N (IDLE).
- Write: `mem_write`=1 in cycle N+1 only; memory captures at end of N+1; IDLE in N+2; next accept possible in N+2. Peak throughput is one write per 2 cycles.
- Read: `mem_read`=1 in cycles N+1 … N+READ_LATENCY. Sample at the end of N+READ_LATENCY. `rvalid`=1 in cycle N+READ_LATENCY+1, which is also IDLE.
- `busy` is high in N+1 … N+READ_LATENCY (read) or N+1 (write).

## Configuration
- `ARB_GRANT_COUNT_EN` defined:
  - `grant_count0`/`grant_count1` ports exist.
  - Each counter increments on its port's accept and saturates at all-ones.
  - Counters clear on reset.
- Undefined: the counter ports and logic are absent; behaviour is otherwise identical.

## Structure
- Package `memory_arbiter_pkg`:
  - state encoding (IDLE, ACCESS, READ_WAIT)
  - port id constants `PORT0`=0, `PORT1`=1
  - default `ADDR_WIDTH`/`DATA_WIDTH`
- One sub-module `rr_arbiter_2`: combinational 2-way round-robin pick from (valid0, valid1, last_grant, enable), producing grant id and grant-valid.
- FSM, command registers and response registers stay in the top module.

## Test plan
- Reset then port 0 write 25 to address 30 → `mem_write` high for exactly 1 cycle with address 30, data 25; `busy` 1 cycle; ready again 2 cycles after accept.
- Port 1 read address 30 after the above, `READ_LATENCY`=1 → `req1_rvalid` pulse 2 cycles after accept with `req1_rdata`=25; `req0_rvalid` stays 0.
- Both ports valid continuously (port 0 write 15 to address 20, port 1 write 18 to address 10) → grants alternate 0,1,0,1; never both ready in the same cycle.
- Port 0 read at address 31 with `READ_LATENCY`=3 → `mem_read` high 3 cycles, `rvalid` in cycle N+4, address 31 unchanged on the bus.
- Reset asserted in the cycle after a read accept → next cycle `mem_read`=0, `busy`=0, no `rvalid`; port 0 wins the next contention.
- With `ARB_GRANT_COUNT_EN`, `COUNT_WIDTH`=2: five port-1 accepts → `grant_count1` = 3 (saturated), `grant_count0` = 0.
